alu_cmd_sequencer: RTL and testbench

- Command front-end and result stage for the combinational 8-bit ALU.
- Accepts {opcode, operand_a, operand_b} commands over a valid/ready handshake and buffers them in a small FIFO.
- Presents one command at a time to the ALU, then registers the ALU's 16-bit result and carry/borrow flags into an output slot.
- Adds zero and divide-by-zero status and delivers results downstream with valid/ready back-pressure.

---
 rtl/alu_cmd_sequencer.sv | 159 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Command FIFO front-end and registered result stage for a
//               combinational 8-bit ALU, with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    output logic [3:0]       alu_opcode,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic [15:0]      alu_out,
    input  logic             alu_cout,
    input  logic             alu_bout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic [3:0]       res_opcode,
    output logic             res_cout,
    output logic             res_bout,
    output logic             res_zero,
    output logic             res_divz,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_depth  = CNT_W'(DEPTH);
    localparam logic [3:0]       c_op_mod = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [3:0]       r_mem_op [DEPTH];
    logic [7:0]       r_mem_a  [DEPTH];
    logic [7:0]       r_mem_b  [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [3:0]       w_head_op;
    logic [7:0]       w_head_a;
    logic [7:0]       w_head_b;

    logic             r_res_valid;
    logic [15:0]      r_res_data;
    logic [3:0]       r_res_opcode;
    logic             r_res_cout;
    logic             r_res_bout;
    logic             r_res_zero;
    logic             r_res_divz;

    assign w_empty   = (r_count == '0);
    assign cmd_ready = (r_count < c_depth);
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = (r_state == EXEC);

    assign w_head_op = r_mem_op[r_rd_ptr];
    assign w_head_a  = r_mem_a[r_rd_ptr];
    assign w_head_b  = r_mem_b[r_rd_ptr];

    // ALU sees zeros when nothing is queued so its inputs never show stale data
    assign alu_opcode = w_empty ? 4'd0 : w_head_op;
    assign alu_a      = w_empty ? 8'd0 : w_head_a;
    assign alu_b      = w_empty ? 8'd0 : w_head_b;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr] <= cmd_opcode;
            r_mem_a[r_wr_ptr]  <= cmd_a;
            r_mem_b[r_wr_ptr]  <= cmd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Leaving HOLD also considers a push landing on the same edge
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!w_empty) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = HOLD;
            HOLD:    if (res_ready) w_state_nxt = (!w_empty || w_push) ? EXEC : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_opcode <= '0;
            r_res_cout   <= 1'b0;
            r_res_bout   <= 1'b0;
            r_res_zero   <= 1'b0;
            r_res_divz   <= 1'b0;
        end else if (r_state == EXEC) begin
            r_res_valid  <= 1'b1;
            r_res_data   <= alu_out;
            r_res_opcode <= w_head_op;
            r_res_cout   <= alu_cout;
            r_res_bout   <= alu_bout;
            r_res_zero   <= (alu_out == 16'd0);
            r_res_divz   <= (w_head_op == c_op_mod) && (w_head_b == 8'd0);
        end else if ((r_state == HOLD) && res_ready) begin
            r_res_valid  <= 1'b0;
        end
    end

    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_opcode = r_res_opcode;
    assign res_cout   = r_res_cout;
    assign res_bout   = r_res_bout;
    assign res_zero   = r_res_zero;
    assign res_divz   = r_res_divz;
    assign busy       = (r_state != IDLE) || !w_empty;
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Self-checking bench for alu_cmd_sequencer with a queue-based
//               reference model and a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [15:0] alu_out;
    logic        alu_cout;
    logic        alu_bout;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [3:0]  res_opcode;
    logic        res_cout;
    logic        res_bout;
    logic        res_zero;
    logic        res_divz;
    logic        busy;
    logic [2:0]  fifo_count;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    cmd_t        r_model_q[$];
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          n_results = 0;
    logic        r_prev_stall = 1'b0;
    logic [23:0] r_prev_res;
    logic [23:0] w_cur_res;

    alu_cmd_sequencer #(.DEPTH(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_cout   (alu_cout),
        .alu_bout   (alu_bout),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_opcode (res_opcode),
        .res_cout   (res_cout),
        .res_bout   (res_bout),
        .res_zero   (res_zero),
        .res_divz   (res_divz),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {result[15:0], cout, bout}
    function automatic logic [17:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
        logic [8:0]  s;
        logic [15:0] r;
        logic        c;
        logic        bo;
        c  = 1'b0;
        bo = 1'b0;
        s  = '0;
        case (op)
            4'd0:    begin s = {1'b0, a} + {1'b0, b}; r = {8'd0, s[7:0]}; c = s[8]; end
            4'd1:    begin s = {1'b0, a} - {1'b0, b}; r = {8'd0, s[7:0]}; bo = (a < b); end
            4'd2:    r = 16'(a) * 16'(b);
            4'd3:    r = (b == 8'd0) ? 16'd0 : {8'd0, a % b};
            4'd9:    r = {8'd0, a & b};
            4'd15:   r = (a == b) ? 16'd1 : 16'd0;
            default: r = {a ^ b, a | b};
        endcase
        return {r, c, bo};
    endfunction

    always_comb {alu_out, alu_cout, alu_bout} = alu_model(alu_opcode, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    assign w_cur_res = {res_data, res_opcode, res_cout, res_bout, res_zero, res_divz};

    // Monitor: sampled on the falling edge, reflecting what the next rising edge will do
    always @(negedge clk) begin
        cmd_t        c;
        logic [17:0] e;
        if (rst) begin
            r_model_q.delete();
            r_prev_stall = 1'b0;
        end else begin
            if (r_prev_stall) begin
                check("stall_valid", 32'(res_valid), 32'd1);
                check("stall_stable", 32'(w_cur_res), 32'(r_prev_res));
            end
            if (res_valid && res_ready) begin
                n_results++;
                if (r_model_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    c = r_model_q.pop_front();
                    e = alu_model(c.op, c.a, c.b);
                    check("res_data", 32'(res_data), 32'(e[17:2]));
                    check("res_opcode", 32'(res_opcode), 32'(c.op));
                    check("res_cout", 32'(res_cout), 32'(e[1]));
                    check("res_bout", 32'(res_bout), 32'(e[0]));
                    check("res_zero", 32'(res_zero), 32'(e[17:2] == 16'd0));
                    check("res_divz", 32'(res_divz), 32'((c.op == 4'd3) && (c.b == 8'd0)));
                end
            end
            if (cmd_valid && cmd_ready)
                r_model_q.push_back('{op: cmd_opcode, a: cmd_a, b: cmd_b});
            r_prev_stall = res_valid && !res_ready;
            r_prev_res   = w_cur_res;
        end
    end

    task automatic push_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1'b1; break; end
        end
        if (!ok) check("res_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && !res_valid) begin ok = 1'b1; break; end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] ops [6];
        int         r0;
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9, 4'd15};
        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_fields", 32'(w_cur_res), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        // Add with carry; latency from acceptance edge N to res_valid at N+2
        push_cmd(4'b0000, 8'd200, 8'd100);
        @(negedge clk); check("lat_n", 32'(res_valid), 32'd0);
        @(negedge clk); check("lat_n1", 32'(res_valid), 32'd0);
        @(negedge clk); check("lat_n2", 32'(res_valid), 32'd1);
        check("t1_data", 32'(res_data), 32'h002C);
        check("t1_cout", 32'(res_cout), 32'd1);
        check("t1_zero", 32'(res_zero), 32'd0);
        check("t1_count", 32'(fifo_count), 32'd0);
        @(posedge clk); #1;

        push_cmd(4'b0010, 8'd255, 8'd255);
        wait_res();
        check("t2_data", 32'(res_data), 32'hFE01);
        check("t2_opcode", 32'(res_opcode), 32'h2);
        check("t2_divz", 32'(res_divz), 32'd0);
        @(posedge clk); #1;

        push_cmd(4'b0011, 8'd37, 8'd0);
        wait_res();
        check("t3_data", 32'(res_data), 32'h0000);
        check("t3_zero", 32'(res_zero), 32'd1);
        check("t3_divz", 32'(res_divz), 32'd1);
        wait_idle();

        // Back-pressure: one result held, FIFO fills, sixth command must wait
        res_ready = 1'b0;
        r0 = n_results;
        for (int k = 0; k < 5; k++)
            push_cmd(ops[$urandom_range(0, 5)], 8'($urandom), 8'($urandom));
        @(negedge clk);
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_res_valid", 32'(res_valid), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_opcode = 4'd1; cmd_a = 8'd3; cmd_b = 8'd9;
        repeat (3) begin
            @(negedge clk);
            check("full_wait", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        cmd_valid = 1'b0;
        push_cmd(4'd1, 8'd3, 8'd9);
        wait_idle();
        check("t4_result_count", 32'(n_results - r0), 32'd6);

        push_cmd(4'b1111, 8'd7, 8'd7);
        push_cmd(4'b1001, 8'hF0, 8'h0F);
        wait_res();
        check("t5a_data", 32'(res_data), 32'h0001);
        check("t5a_zero", 32'(res_zero), 32'd0);
        @(posedge clk);
        wait_res();
        check("t5b_data", 32'(res_data), 32'h0000);
        check("t5b_zero", 32'(res_zero), 32'd1);
        wait_idle();

        // Reset while holding a result with two commands queued
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) push_cmd(4'd2, 8'(k + 5), 8'd11);
        @(negedge clk);
        check("t6_pre_count", 32'(fifo_count), 32'd2);
        check("t6_pre_valid", 32'(res_valid), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_res_valid", 32'(res_valid), 32'd0);
        check("t6_count", 32'(fifo_count), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        res_ready = 1'b1;
        r0 = n_results;
        repeat (10) @(negedge clk);
        check("t6_no_stale", 32'(n_results - r0), 32'd0);
        check("t6_idle_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;

        // Randomized traffic with random back-pressure
        repeat (400) begin
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_opcode = ($urandom_range(0, 7) < 6) ? ops[$urandom_range(0, 5)] : 4'($urandom);
            cmd_a      = 8'($urandom);
            cmd_b      = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            res_ready  = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        wait_idle();
        check("drain_queue_empty", 32'(r_model_q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
